net_inject_adapter: RTL and testbench

Per-terminal network interface that sits directly upstream of the 4-port ring network on one terminal (port `terminal_id`). On injection, it stamps each client payload with a `net_hdr_t` header (src, dest, sequence opaque), buffers it, and drives the ring `in_*` port. On ejection, it accepts the ring `out_*` port for the same terminal and returns source, opaque and payload to the client. A credit counter caps how many messages may be in flight at once.

---
 rtl/net_msgs_pkg.sv | 17 +
 rtl/vc_Queue.sv | 54 +++++
 rtl/net_inject_adapter.sv | 124 ++++++++++++
 tb/tb_net_inject_adapter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_msgs_pkg.sv
// Shared network message definitions: header layout and field widths used by
// every terminal on the 4-port ring.
package net_msgs_pkg;

  localparam int c_net_opaque_nbits  = 8;
  localparam int c_net_srcdest_nbits = 2;
  localparam int c_net_nports        = 4;

  typedef struct packed {
    logic [c_net_opaque_nbits-1:0]  opaque;
    logic [c_net_srcdest_nbits-1:0] src;
    logic [c_net_srcdest_nbits-1:0] dest;
  } net_hdr_t;

  localparam int c_net_hdr_nbits = $bits(net_hdr_t);

endpackage

// File: rtl/vc_Queue.sv
// Normal (non-bypass, non-pipe) circular-buffer queue: a message enqueued in
// cycle t is visible at the head in cycle t+1; a full queue never accepts.
module vc_Queue #(
  parameter int p_msg_nbits = 1,
  parameter int p_num_msgs  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq_val,
  output logic                   enq_rdy,
  input  logic [p_msg_nbits-1:0] enq_msg,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [p_msg_nbits-1:0] deq_msg
);

  localparam int c_addr_nbits = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
  localparam int c_cnt_nbits  = $clog2(p_num_msgs + 1);

  logic [p_msg_nbits-1:0]  entries [p_num_msgs];
  logic [c_addr_nbits-1:0] enq_ptr;
  logic [c_addr_nbits-1:0] deq_ptr;
  logic [c_cnt_nbits-1:0]  count;
  logic                    enq_fire;
  logic                    deq_fire;

  function automatic logic [c_addr_nbits-1:0] ptr_next(input logic [c_addr_nbits-1:0] p);
    return (p == c_addr_nbits'(p_num_msgs - 1)) ? '0 : p + 1'b1;
  endfunction

  assign enq_rdy  = (count != c_cnt_nbits'(p_num_msgs));
  assign deq_val  = (count != '0);
  assign deq_msg  = entries[deq_ptr];
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
      for (int i = 0; i < p_num_msgs; i++) entries[i] <= '0;
    end else begin
      if (enq_fire) begin
        entries[enq_ptr] <= enq_msg;
        enq_ptr          <= ptr_next(enq_ptr);
      end
      if (deq_fire) deq_ptr <= ptr_next(deq_ptr);
      if (enq_fire && !deq_fire)      count <= count + 1'b1;
      else if (deq_fire && !enq_fire) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/net_inject_adapter.sv
// Terminal network interface: stamps client requests with a ring header and
// injects them, returns ejected messages to the client, and caps in-flight count.
module net_inject_adapter
  import net_msgs_pkg::*;
#(
  parameter int p_payload_nbits = 32,
  parameter int p_max_outst     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 terminal_id,
  input  logic [1:0]                 req_dest,
  input  logic [p_payload_nbits-1:0] req_payload,
  input  logic                       req_val,
  output logic                       req_rdy,
  output net_hdr_t                   net_out_msg_hdr,
  output logic [p_payload_nbits-1:0] net_out_msg_payload,
  output logic                       net_out_val,
  input  logic                       net_out_rdy,
  input  net_hdr_t                   net_in_msg_hdr,
  input  logic [p_payload_nbits-1:0] net_in_msg_payload,
  input  logic                       net_in_val,
  output logic                       net_in_rdy,
  output logic [1:0]                 resp_src,
  output logic [7:0]                 resp_opaque,
  output logic [p_payload_nbits-1:0] resp_payload,
  output logic                       resp_val,
  input  logic                       resp_rdy,
  output logic [3:0]                 outst_count,
  output logic                       misroute_err
);

  localparam int c_inj_nbits = c_net_hdr_nbits + p_payload_nbits;

  logic [7:0]                 seq_q;
  logic [3:0]                 outst_q;
  logic                       misroute_q;
  logic                       inj_enq_rdy;
  logic                       credit_avail;
  logic                       req_fire;
  logic                       resp_fire;
  logic                       in_fire;
  logic                       zero_credit_resp;
  net_hdr_t                   req_hdr;
  logic [c_inj_nbits-1:0]     inj_deq_msg;
  logic                       vld_p1;
  logic [1:0]                 src_p1;
  logic [7:0]                 opaque_p1;
  logic [p_payload_nbits-1:0] payload_p1;

  // Saturating credit update; a simultaneous send and return cancel out.
  function automatic logic [3:0] credit_next(input logic [3:0] cnt, input logic inc,
                                             input logic dec);
    if (inc && !dec && cnt < 4'(p_max_outst)) return cnt + 4'd1;
    if (dec && !inc && cnt != 4'd0)           return cnt - 4'd1;
    return cnt;
  endfunction

  assign credit_avail = (outst_q < 4'(p_max_outst));
  assign req_rdy      = !reset && inj_enq_rdy && credit_avail;
  assign req_fire     = req_val && req_rdy;
  assign req_hdr      = '{opaque: seq_q, src: terminal_id, dest: req_dest};

  // Stage p0: header stamping and injection buffering
  vc_Queue #(
    .p_msg_nbits (c_inj_nbits),
    .p_num_msgs  (2)
  ) inj_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (req_fire),
    .enq_rdy (inj_enq_rdy),
    .enq_msg ({req_hdr, req_payload}),
    .deq_val (net_out_val),
    .deq_rdy (net_out_rdy),
    .deq_msg (inj_deq_msg)
  );

  assign net_out_msg_hdr     = inj_deq_msg[c_inj_nbits-1 -: c_net_hdr_nbits];
  assign net_out_msg_payload = inj_deq_msg[p_payload_nbits-1:0];

  assign net_in_rdy       = !vld_p1 || resp_rdy;
  assign in_fire          = net_in_val && net_in_rdy;
  assign resp_fire        = vld_p1 && resp_rdy;
  assign zero_credit_resp = resp_fire && !req_fire && (outst_q == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q      <= '0;
      outst_q    <= '0;
      misroute_q <= 1'b0;
    end else begin
      if (req_fire) seq_q <= seq_q + 8'd1;
      outst_q <= credit_next(outst_q, req_fire, resp_fire);
      if (zero_credit_resp || (in_fire && net_in_msg_hdr.dest != terminal_id))
        misroute_q <= 1'b1;
    end
  end

  // Stage p1: ejection pipe register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      src_p1     <= '0;
      opaque_p1  <= '0;
      payload_p1 <= '0;
    end else if (in_fire) begin
      vld_p1     <= 1'b1;
      src_p1     <= net_in_msg_hdr.src;
      opaque_p1  <= net_in_msg_hdr.opaque;
      payload_p1 <= net_in_msg_payload;
    end else if (resp_fire) begin
      vld_p1     <= 1'b0;
    end
  end

  assign resp_val     = vld_p1;
  assign resp_src     = src_p1;
  assign resp_opaque  = opaque_p1;
  assign resp_payload = payload_p1;
  assign outst_count  = outst_q;
  assign misroute_err = misroute_q;

endmodule

// File: tb/tb_net_inject_adapter.sv
// Bench for net_inject_adapter: acts as client and as a loopback ring, checking
// every cycle against a queue-based model of messages in flight.
module tb_net_inject_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  terminal_id;
  logic [1:0]  req_dest;
  logic [31:0] req_payload;
  logic        req_val;
  logic        req_rdy;
  logic [11:0] net_out_msg_hdr;
  logic [31:0] net_out_msg_payload;
  logic        net_out_val;
  logic        net_out_rdy;
  logic [11:0] net_in_msg_hdr;
  logic [31:0] net_in_msg_payload;
  logic        net_in_val;
  logic        net_in_rdy;
  logic [1:0]  resp_src;
  logic [7:0]  resp_opaque;
  logic [31:0] resp_payload;
  logic        resp_val;
  logic        resp_rdy;
  logic [3:0]  outst_count;
  logic        misroute_err;

  net_inject_adapter #(.p_payload_nbits(32), .p_max_outst(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .terminal_id         (terminal_id),
    .req_dest            (req_dest),
    .req_payload         (req_payload),
    .req_val             (req_val),
    .req_rdy             (req_rdy),
    .net_out_msg_hdr     (net_out_msg_hdr),
    .net_out_msg_payload (net_out_msg_payload),
    .net_out_val         (net_out_val),
    .net_out_rdy         (net_out_rdy),
    .net_in_msg_hdr      (net_in_msg_hdr),
    .net_in_msg_payload  (net_in_msg_payload),
    .net_in_val          (net_in_val),
    .net_in_rdy          (net_in_rdy),
    .resp_src            (resp_src),
    .resp_opaque         (resp_opaque),
    .resp_payload        (resp_payload),
    .resp_val            (resp_val),
    .resp_rdy            (resp_rdy),
    .outst_count         (outst_count),
    .misroute_err        (misroute_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] hdr;
    logic [31:0] pl;
  } msg_t;

  // Model: accepted-not-injected, injected-not-returned, ejected-not-delivered
  msg_t       inj_q[$];
  msg_t       loop_q[$];
  msg_t       ej_q[$];
  logic [7:0] out_opq[$];
  logic [7:0] dlv_opq[$];
  int         m_outst;
  int         m_seq;
  bit         m_err;
  bit         feeding;
  int         acc;
  int         max_outst;
  int         total;
  int         bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ring(input bit en);
    if (en && loop_q.size() != 0) begin
      net_in_val         = 1'b1;
      net_in_msg_hdr     = loop_q[0].hdr;
      net_in_msg_payload = loop_q[0].pl;
      feeding            = 1'b1;
    end else begin
      net_in_val = 1'b0;
      feeding    = 1'b0;
    end
  endtask

  task automatic cyc();
    bit   exp_rdy, exp_nin, rf, of, inf, sf;
    msg_t m;
    #1;
    exp_rdy = (inj_q.size() < 2) && (m_outst < 4);
    exp_nin = (ej_q.size() == 0) || resp_rdy;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("net_in_rdy", 64'(net_in_rdy), 64'(exp_nin));
    chk("outst_count", 64'(outst_count), 64'(m_outst));
    chk("misroute_err", 64'(misroute_err), 64'(m_err));
    chk("net_out_val", 64'(net_out_val), 64'(inj_q.size() != 0));
    chk("resp_val", 64'(resp_val), 64'(ej_q.size() != 0));
    if (inj_q.size() != 0) begin
      chk("net_out_hdr", 64'(net_out_msg_hdr), 64'(inj_q[0].hdr));
      chk("net_out_payload", 64'(net_out_msg_payload), 64'(inj_q[0].pl));
    end
    if (ej_q.size() != 0) begin
      chk("resp_src", 64'(resp_src), 64'(ej_q[0].hdr[3:2]));
      chk("resp_opaque", 64'(resp_opaque), 64'(ej_q[0].hdr[11:4]));
      chk("resp_payload", 64'(resp_payload), 64'(ej_q[0].pl));
    end
    rf  = req_val && exp_rdy;
    of  = net_out_rdy && (inj_q.size() != 0);
    inf = net_in_val && exp_nin;
    sf  = resp_rdy && (ej_q.size() != 0);
    if (of) begin
      m = inj_q.pop_front();
      loop_q.push_back(m);
      out_opq.push_back(m.hdr[11:4]);
    end
    if (inf) begin
      m.hdr = net_in_msg_hdr;
      m.pl  = net_in_msg_payload;
      ej_q.push_back(m);
      if (m.hdr[1:0] != terminal_id) m_err = 1'b1;
      if (feeding) void'(loop_q.pop_front());
    end
    if (sf) begin
      m = ej_q.pop_front();
      dlv_opq.push_back(m.hdr[11:4]);
    end
    if (rf && !sf) m_outst++;
    else if (sf && !rf) begin
      if (m_outst == 0) m_err = 1'b1;
      else m_outst--;
    end
    if (rf) begin
      m.hdr = {8'(m_seq), terminal_id, req_dest};
      m.pl  = req_payload;
      inj_q.push_back(m);
      m_seq = (m_seq + 1) % 256;
      acc++;
    end
    if (int'(outst_count) > max_outst) max_outst = int'(outst_count);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    req_val            = 1'b0;
    req_dest           = '0;
    req_payload        = '0;
    net_out_rdy        = 1'b0;
    net_in_val         = 1'b0;
    net_in_msg_hdr     = '0;
    net_in_msg_payload = '0;
    resp_rdy           = 1'b0;
    feeding            = 1'b0;
    inj_q.delete();
    loop_q.delete();
    ej_q.delete();
    out_opq.delete();
    dlv_opq.delete();
    m_outst = 0;
    m_seq   = 0;
    m_err   = 1'b0;
    #1;
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_net_out_val", 64'(net_out_val), 64'(0));
    chk("rst_resp_val", 64'(resp_val), 64'(0));
    chk("rst_outst", 64'(outst_count), 64'(0));
    chk("rst_misroute", 64'(misroute_err), 64'(0));
    chk("rst_out_data", {20'd0, net_out_msg_hdr, net_out_msg_payload}, 64'(0));
    chk("rst_resp_data", {22'd0, resp_src, resp_opaque, resp_payload}, 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && (inj_q.size() + loop_q.size() + ej_q.size()) != 0; c++) begin
      req_val     = 1'b0;
      net_out_rdy = 1'b1;
      resp_rdy    = 1'b1;
      drive_ring(1'b1);
      cyc();
    end
    drive_ring(1'b0);
    resp_rdy = 1'b0;
    chk("drained", 64'(inj_q.size() + loop_q.size() + ej_q.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pl;
    total       = 0;
    bad         = 0;
    max_outst   = 0;
    terminal_id = 2'd2;
    do_reset();

    // single send, looped back
    req_val = 1'b1; req_dest = 2'd1; req_payload = 32'hCAFEF00D;
    cyc();
    req_val = 1'b0;
    chk("single_hdr", 64'(net_out_msg_hdr), 64'(12'h009));
    chk("single_cnt1", 64'(outst_count), 64'(1));
    net_out_rdy = 1'b1;
    cyc();
    net_out_rdy = 1'b0;
    drive_ring(1'b1);
    cyc();
    drive_ring(1'b0);
    chk("single_src", 64'(resp_src), 64'(2));
    chk("single_opaque", 64'(resp_opaque), 64'(0));
    chk("single_payload", 64'(resp_payload), 64'(32'hCAFEF00D));
    resp_rdy = 1'b1;
    cyc();
    resp_rdy = 1'b0;
    chk("single_cnt0", 64'(outst_count), 64'(0));

    // credit limit
    do_reset();
    acc = 0; net_out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_val = 1'b1; req_dest = 2'($urandom); req_payload = $urandom;
      cyc();
    end
    chk("credit_accepted", 64'(acc), 64'(4));
    drive_ring(1'b1);
    cyc();
    drive_ring(1'b0);
    chk("credit_hold", 64'(req_rdy), 64'(0));
    resp_rdy = 1'b1;
    #1;
    chk("credit_same_cycle", 64'(req_rdy), 64'(0));
    cyc();
    resp_rdy = 1'b0;
    #1;
    chk("credit_next_cycle", 64'(req_rdy), 64'(1));
    cyc();
    drain();

    // backpressure
    do_reset();
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      req_val = 1'b1; req_dest = 2'($urandom); req_payload = $urandom;
      cyc();
    end
    chk("bp_accepted", 64'(acc), 64'(2));
    chk("bp_req_rdy", 64'(req_rdy), 64'(0));
    req_val = 1'b0; net_out_rdy = 1'b1;
    cyc();
    cyc();
    chk("bp_out_count", 64'(out_opq.size()), 64'(2));
    if (out_opq.size() == 2) begin
      chk("bp_first_opaque", 64'(out_opq[0]), 64'(0));
      chk("bp_second_opaque", 64'(out_opq[1]), 64'(1));
    end
    drain();

    // wraparound with random traffic
    do_reset();
    acc = 0; max_outst = 0;
    for (int c = 0; c < 6000 && !(acc >= 257 && (inj_q.size() + loop_q.size() + ej_q.size()) == 0); c++) begin
      req_val     = (acc < 257) && ($urandom_range(0, 3) != 0);
      req_dest    = 2'($urandom);
      req_payload = $urandom;
      net_out_rdy = ($urandom_range(0, 3) != 0);
      resp_rdy    = ($urandom_range(0, 3) != 0);
      drive_ring($urandom_range(0, 2) != 0);
      cyc();
    end
    chk("wrap_delivered", 64'(dlv_opq.size()), 64'(257));
    if (dlv_opq.size() == 257) begin
      chk("wrap_opaque_255", 64'(dlv_opq[255]), 64'(255));
      chk("wrap_opaque_256", 64'(dlv_opq[256]), 64'(0));
    end
    chk("wrap_max_outst", 64'(max_outst <= 4), 64'(1));
    drain();

    // simultaneous request and response at count 2
    do_reset();
    net_out_rdy = 1'b1; req_val = 1'b1; req_payload = $urandom;
    cyc();
    req_payload = $urandom;
    cyc();
    req_val = 1'b0;
    cyc();
    drive_ring(1'b1);
    cyc();
    drive_ring(1'b0);
    chk("sim_pre", 64'(outst_count), 64'(2));
    req_val = 1'b1; resp_rdy = 1'b1;
    cyc();
    req_val = 1'b0; resp_rdy = 1'b0;
    chk("sim_cnt", 64'(outst_count), 64'(2));
    drain();

    // response fire with zero credits outstanding
    do_reset();
    net_in_val = 1'b1; net_in_msg_hdr = {8'h42, 2'd3, terminal_id}; net_in_msg_payload = $urandom;
    cyc();
    net_in_val = 1'b0; resp_rdy = 1'b1;
    cyc();
    resp_rdy = 1'b0;
    chk("zero_cnt", 64'(outst_count), 64'(0));
    chk("zero_err", 64'(misroute_err), 64'(1));

    // misrouted arrival
    terminal_id = 2'd0;
    do_reset();
    pl = $urandom;
    net_in_val = 1'b1; net_in_msg_hdr = {8'h55, 2'd1, 2'd3}; net_in_msg_payload = pl;
    cyc();
    net_in_val = 1'b0;
    chk("mis_payload", 64'(resp_payload), 64'(pl));
    chk("mis_err", 64'(misroute_err), 64'(1));
    resp_rdy = 1'b1;
    cyc();
    cyc();
    resp_rdy = 1'b0;
    chk("mis_sticky", 64'(misroute_err), 64'(1));

    // asynchronous reset mid-stream
    terminal_id = 2'd1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      req_val     = (c < 3) || ($urandom_range(0, 1) != 0);
      req_dest    = 2'($urandom);
      req_payload = $urandom;
      net_out_rdy = ($urandom_range(0, 1) != 0);
      resp_rdy    = 1'b0;
      drive_ring(1'b1);
      cyc();
    end
    chk("pre_reset_busy", 64'(outst_count != 0), 64'(1));
    #2;
    do_reset();
    req_val = 1'b1; req_dest = 2'd2; req_payload = $urandom;
    cyc();
    req_val = 1'b0;
    chk("post_reset_opaque", 64'(net_out_msg_hdr[11:4]), 64'(0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
